// File: rtl/coin_game_pkg.sv
// Shared types and constants for the coin hit judge.
// State encoding is exported on o_state for debug.
package coin_game_pkg;

    localparam int SCORE_W           = 16;
    localparam int STREAK_W          = 8;
    localparam int GAP_FRAMES_DEF    = 30;
    localparam int WINDOW_FRAMES_DEF = 12;
    localparam int TRAVEL_FRAMES_DEF = 60;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARMED  = 3'd2,
        S_HIT    = 3'd3,
        S_MISS   = 3'd4,
        S_GAP    = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer and rising-edge detector.
// Press pulse is registered: three cycles from i_btn to o_press.
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_press <= r_sync & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/coin_hit_judge.sv
// Judges button presses against a travelling coin sprite.
// Tracks score and streak; all outputs come from flops.
module coin_hit_judge
    import coin_game_pkg::*;
#(
    parameter int GAP_FRAMES    = GAP_FRAMES_DEF,
    parameter int WINDOW_FRAMES = WINDOW_FRAMES_DEF,
    parameter int TRAVEL_FRAMES = TRAVEL_FRAMES_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_tick,
    input  logic                i_enable,
    input  logic                i_btn,
    input  logic                i_in_position,
    output logic                o_active,
    output logic                o_hit_pulse,
    output logic                o_miss_pulse,
    output logic [SCORE_W-1:0]  o_score,
    output logic [STREAK_W-1:0] o_streak,
    output logic [2:0]          o_state
);

    localparam int CNT_MAX = max3(GAP_FRAMES, WINDOW_FRAMES, TRAVEL_FRAMES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e              r_state;
    state_e              w_next;
    logic [CW-1:0]       r_cnt;
    logic                w_press;
    logic                w_counting;
    logic                r_active;
    logic                r_hit;
    logic                r_miss;
    logic [SCORE_W-1:0]  r_score;
    logic [STREAK_W-1:0] r_streak;

    btn_sync_edge u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn),
        .o_press (w_press)
    );

    assign w_counting = (r_state == S_LAUNCH) ||
                        (r_state == S_ARMED)  ||
                        (r_state == S_GAP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!i_enable) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_next = S_LAUNCH;
                S_LAUNCH: begin
                    if (i_in_position)
                        w_next = S_ARMED;
                    else if (w_press)
                        w_next = S_MISS;
                    else if (r_cnt >= CW'(TRAVEL_FRAMES))
                        w_next = S_MISS;
                end
                S_ARMED: begin
                    // a press beats any window-close in the same cycle
                    if (w_press)
                        w_next = S_HIT;
                    else if (!i_in_position ||
                             r_cnt >= CW'(WINDOW_FRAMES))
                        w_next = S_MISS;
                end
                S_HIT:  w_next = S_GAP;
                S_MISS: w_next = S_GAP;
                S_GAP: begin
                    if (r_cnt >= CW'(GAP_FRAMES))
                        w_next = S_LAUNCH;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Any state change restarts the frame count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (i_frame_tick && w_counting &&
                     r_cnt != CW'(CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_active <= (w_next == S_LAUNCH) || (w_next == S_ARMED);
            r_hit    <= (w_next == S_HIT);
            r_miss   <= (w_next == S_MISS);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score  <= '0;
            r_streak <= '0;
        end else if (w_next == S_HIT) begin
            if (r_score != '1)
                r_score <= r_score + 1'b1;
            if (r_streak != '1)
                r_streak <= r_streak + 1'b1;
        end else if (w_next == S_MISS) begin
            r_streak <= '0;
        end
    end

    assign o_active     = r_active;
    assign o_hit_pulse  = r_hit;
    assign o_miss_pulse = r_miss;
    assign o_score      = r_score;
    assign o_streak     = r_streak;
    assign o_state      = r_state;

endmodule

// File: tb/tb_coin_hit_judge.sv
// Directed bench for coin_hit_judge at default frame parameters.
// Frame tick every 4 clocks; inputs driven on the falling edge.
module tb_coin_hit_judge;
    import coin_game_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick  = 1'b0;
    logic        en    = 1'b0;
    logic        btn   = 1'b0;
    logic        inpos = 1'b0;
    logic        o_active;
    logic        o_hit_pulse;
    logic        o_miss_pulse;
    logic [15:0] o_score;
    logic [7:0]  o_streak;
    logic [2:0]  o_state;

    int n_chk  = 0;
    int n_pass = 0;
    int n_hit  = 0;
    int n_miss = 0;
    int tcnt   = 0;
    int cnt;

    coin_hit_judge dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_tick  (tick),
        .i_enable      (en),
        .i_btn         (btn),
        .i_in_position (inpos),
        .o_active      (o_active),
        .o_hit_pulse   (o_hit_pulse),
        .o_miss_pulse  (o_miss_pulse),
        .o_score       (o_score),
        .o_streak      (o_streak),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (o_hit_pulse)  n_hit  = n_hit + 1;
        if (o_miss_pulse) n_miss = n_miss + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_active(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            seen = o_active;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input bit hit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            seen = hit ? o_hit_pulse : o_miss_pulse;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c = c + 1;
        end
        @(negedge clk);
    endtask

    // which: 0 active rise, 1 hit pulse, 2 miss pulse
    task automatic count_ticks(input int which, output int n);
        logic t;
        logic s;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            t = tick;
            @(negedge clk);
            s = (which == 0) ? o_active :
                (which == 1) ? o_hit_pulse : o_miss_pulse;
            if (s) return;
            n = n + int'(t);
        end
        n = -1;
    endtask

    task automatic do_hit(input string tag);
        wait_active({tag, "_launch"});
        @(negedge clk);
        inpos = 1'b1;
        @(negedge clk);
        btn = 1'b1;
        wait_pulse({tag, "_pulse"}, 1'b1);
        #1;
        inpos = 1'b0;
        btn   = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_hit", 32'(o_hit_pulse), 32'd0);
        chk("rst_miss", 32'(o_miss_pulse), 32'd0);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_streak", 32'(o_streak), 32'd0);
        chk("rst_state", 32'(o_state), 32'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // normal hit: rise at frame 20, press at frame 22
        wait_active("hit_launch");
        wait_ticks(20);
        inpos = 1'b1;
        wait_ticks(2);
        btn = 1'b1;
        wait_pulse("hit_pulse", 1'b1);
        chk("hit_state", 32'(o_state), 32'(S_HIT));
        chk("hit_active", 32'(o_active), 32'd0);
        #1;
        chk("hit_count", 32'(n_hit), 32'd1);
        chk("hit_score", 32'(o_score), 32'd1);
        chk("hit_streak", 32'(o_streak), 32'd1);
        inpos = 1'b0;
        btn   = 1'b0;
        @(posedge clk);
        cnt = -1;
        begin
            logic t;
            int   n;
            n = 0;
            for (int k = 0; k < 2000; k++) begin
                @(posedge clk);
                t = tick;
                @(negedge clk);
                if (o_active) begin
                    cnt = n;
                    break;
                end
                n = n + int'(t);
                if (k == 10) btn = 1'b1;
                if (k == 14) btn = 1'b0;
            end
        end
        chk("gap_frames", 32'(cnt), 32'd30);
        #1;
        chk("gap_press_hit", 32'(n_hit), 32'd1);
        chk("gap_press_miss", 32'(n_miss), 32'd0);

        // window expiry with no press
        @(negedge clk);
        inpos = 1'b1;
        @(posedge clk);
        count_ticks(2, cnt);
        chk("win_frames", 32'(cnt), 32'd12);
        #1;
        chk("win_miss", 32'(n_miss), 32'd1);
        chk("win_streak", 32'(o_streak), 32'd0);
        chk("win_score", 32'(o_score), 32'd1);
        inpos = 1'b0;

        // early press in LAUNCH
        wait_active("early_launch");
        @(negedge clk);
        btn = 1'b1;
        wait_pulse("early_pulse", 1'b0);
        #1;
        chk("early_score", 32'(o_score), 32'd1);
        chk("early_hits", 32'(n_hit), 32'd1);
        chk("early_miss", 32'(n_miss), 32'd2);
        btn = 1'b0;

        // lost coin
        wait_active("lost_launch");
        count_ticks(2, cnt);
        chk("lost_frames", 32'(cnt), 32'd60);
        #1;
        chk("lost_miss", 32'(n_miss), 32'd3);

        // press and in_position fall together
        wait_active("sim_launch");
        @(negedge clk);
        inpos = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        inpos = 1'b0;
        wait_pulse("sim_pulse", 1'b1);
        #1;
        chk("sim_hits", 32'(n_hit), 32'd2);
        chk("sim_miss", 32'(n_miss), 32'd3);
        chk("sim_score", 32'(o_score), 32'd2);
        chk("sim_streak", 32'(o_streak), 32'd1);
        btn = 1'b0;

        // enable drop while armed
        wait_active("en_launch");
        @(negedge clk);
        inpos = 1'b1;
        repeat (2) @(negedge clk);
        chk("en_armed", 32'(o_state), 32'(S_ARMED));
        en = 1'b0;
        @(negedge clk);
        chk("en_idle", 32'(o_state), 32'(S_IDLE));
        chk("en_active", 32'(o_active), 32'd0);
        inpos = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("en_hits", 32'(n_hit), 32'd2);
        chk("en_miss", 32'(n_miss), 32'd3);
        chk("en_score", 32'(o_score), 32'd2);

        // saturation from a preloaded score/streak
        @(negedge clk);
        dut.r_score  = 16'hFFFE;
        dut.r_streak = 8'hFF;
        en = 1'b1;
        do_hit("sat1");
        chk("sat1_score", 32'(o_score), 32'h0000FFFF);
        chk("sat1_streak", 32'(o_streak), 32'h000000FF);
        do_hit("sat2");
        chk("sat2_score", 32'(o_score), 32'h0000FFFF);
        chk("sat2_streak", 32'(o_streak), 32'h000000FF);

        // asynchronous reset while armed
        wait_active("rst_launch");
        @(negedge clk);
        inpos = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_armed", 32'(o_state), 32'(S_ARMED));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(o_active), 32'd0);
        chk("arst_state", 32'(o_state), 32'(S_IDLE));
        chk("arst_score", 32'(o_score), 32'd0);
        chk("arst_streak", 32'(o_streak), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("arst_hits", 32'(n_hit), 32'd4);
        chk("arst_miss", 32'(n_miss), 32'd3);
        inpos = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/coin_hit_judge.md
COIN_HIT_JUDGE -- requirements
Module: coin_hit_judge

Interface
REQ-001 Parameter GAP_FRAMES, default 30: frames `o_active` is held low between coins so the coin sprite returns to its start position.
REQ-002 Parameter WINDOW_FRAMES, default 12: maximum frames the hit window stays open once `i_in_position` rises.
REQ-003 Parameter TRAVEL_FRAMES, default 60: maximum frames from coin launch to `i_in_position` rising before the coin is declared lost.
REQ-004 `i_clk`, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 `i_rst_n`, input, 1: reset; asynchronous assert, active-low.
REQ-006 `i_frame_tick`, input, 1: one-cycle pulse per frame, derived from v-sync and synchronous to `i_clk`.
REQ-007 `i_enable`, input, 1: game running; low forces IDLE.
REQ-008 `i_btn`, input, 1: raw player button, asynchronous to `i_clk`, active-high.
REQ-009 `i_in_position`, input, 1: the coin's in-position flag; the coin is hittable while this is high.
REQ-010 `o_active`, output, 1: drives the coin's `active` input; high means the coin is on screen and travelling.
REQ-011 `o_hit_pulse`, output, 1: one-cycle pulse on each judged hit.
REQ-012 `o_miss_pulse`, output, 1: one-cycle pulse on each judged miss.
REQ-013 `o_score`, output, 16: total hit count, saturating.
REQ-014 `o_streak`, output, 8: consecutive hits, saturating.
REQ-015 `o_state`, output, 3: current FSM state encoding, for debug.

Function
REQ-016 The button path SHALL pass `i_btn` through a 2-FF synchronizer followed by a rising-edge detector; `press` is a one-cycle pulse, and input-to-press latency is 3 cycles.
REQ-017 The FSM states SHALL be IDLE, LAUNCH, ARMED, HIT, MISS and GAP.
REQ-018 IDLE -> LAUNCH when `i_enable`=1; `o_active`=0 in IDLE.
REQ-019 In LAUNCH, `o_active`=1 and a frame counter counts `i_frame_tick` pulses; the FSM SHALL leave LAUNCH on the first matching condition in this priority order:
  - `i_in_position`=1 -> ARMED, frame counter cleared;
  - `press` -> MISS (early press);
  - counter reaches TRAVEL_FRAMES -> MISS.
REQ-020 In ARMED, `o_active`=1; the FSM SHALL leave ARMED on the first matching condition in this priority order:
  - `press` -> HIT;
  - `i_in_position` falls, or the frame counter reaches WINDOW_FRAMES -> MISS.
REQ-021 When `press` and an ARMED-exit condition occur in the same cycle, HIT SHALL win.
REQ-022 HIT and MISS each last exactly 1 cycle, with `o_active`=0; each then -> GAP with the frame counter cleared.
REQ-023 On HIT: `o_hit_pulse`=1, `o_score` += 1 saturating at 16'hFFFF, `o_streak` += 1 saturating at 8'hFF.
REQ-024 On MISS: `o_miss_pulse`=1, `o_streak` <= 0, `o_score` unchanged.
REQ-025 In GAP, `o_active`=0; after GAP_FRAMES frame ticks -> LAUNCH if `i_enable`=1, otherwise -> IDLE.
REQ-026 Presses arriving while in GAP, HIT, MISS or IDLE SHALL be ignored.
REQ-027 `i_enable`=0 in any state SHALL force IDLE on the next cycle, with `o_active`=0; `o_score` and `o_streak` are retained and no pulse is emitted.
REQ-028 Frame counters SHALL advance only on `i_frame_tick`, count to their terminal value, and not wrap.
REQ-029 Outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-030 On `i_rst_n`=0 the block SHALL enter IDLE asynchronously with:
  - `o_active`=0, `o_hit_pulse`=0, `o_miss_pulse`=0, `o_score`=0, `o_streak`=0;
  - frame counters=0, synchronizer flops=0.
REQ-031 Reset asserted mid-coin (in LAUNCH or ARMED) SHALL drop `o_active` immediately and emit no hit or miss pulse.

Structure
REQ-032 Package coin_game_pkg SHALL hold the FSM state enum, the score width (16), the streak width (8) and the default frame constants.
REQ-033 Sub-module btn_sync_edge SHALL implement the REQ-016 synchronizer and edge detector; all other logic is flat.

Verification
REQ-034 Normal hit: enable, raise `i_in_position` at frame 20, press at frame 22 -> one `o_hit_pulse`, `o_score`=1, `o_streak`=1, `o_active` low for 30 frames, then high again.
REQ-035 Window expiry: hold `i_in_position` high with no press -> `o_miss_pulse` exactly 12 frames after the rise, `o_streak`=0.
REQ-036 Early press and lost coin:
  - press in LAUNCH -> MISS, `o_score` unchanged;
  - `i_in_position` never rises -> MISS at frame 60.
REQ-037 Simultaneous press and `i_in_position` fall in the same cycle -> HIT, not MISS.
REQ-038 Saturation: preload score 16'hFFFE and streak 8'hFF, then two hits -> score 16'hFFFF, streak 8'hFF.
REQ-039 Interrupts:
  - `i_rst_n` low during ARMED -> `o_active`=0 asynchronously, no pulses, score=0;
  - `i_enable` low during ARMED -> IDLE, score retained.
